timed_main_memory: RTL and testbench

Block-addressed main memory that backs the direct-mapped cache, with a request/done handshake and configurable access latency. It is the parametrised successor of the combinational main memory: block width, address width, word width, latency and the pre-load window are all parameters. It also adds block writes, which the cache needs for write-back eviction. It sits between the cache controller and the memory array, and serves one block transaction at a time.

---
 rtl/timed_main_memory.sv | 166 ++++++++++++++++
 tb/tb_timed_main_memory.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_main_memory.sv
// -----------------------------------------------------------------------------
// timed_main_memory
//
// Block-addressed main memory sitting behind the direct-mapped cache. One block
// transaction (read or write) is serviced at a time through a req/done
// handshake, with independent, parameterised read and write latencies.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset (control and outData only,
//              storage contents are never touched by reset)
//   req      - transaction request, accepted when ready is high
//   we       - 1 = block write, 0 = block read (sampled on accept)
//   address  - block address (sampled on accept)
//   inData   - write block, offset 0 in the most-significant word
//   ready    - high while idle, i.e. when a request can be accepted
//   done     - one-cycle completion pulse per accepted transaction
//   outData  - last block read, offset 0 in the most-significant word
// -----------------------------------------------------------------------------
module timed_main_memory #(
    parameter int ADDR_W          = 13,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4,
    parameter int INIT_BASE       = 1024,
    parameter int INIT_COUNT      = 8192
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [WORD_W*WORDS_PER_BLOCK-1:0] inData,
    output logic                              ready,
    output logic                              done,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0] outData
);

    localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W   = ADDR_W + OFF_W;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int BLK_W   = WORD_W * WORDS_PER_BLOCK;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } stateType;

    // Flat word index {block address, offset}; works for OFF_W = 0 as well.
    function automatic logic [IDX_W-1:0] wordIndex(input logic [ADDR_W-1:0] blk, input int off);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(blk) << OFF_W;
        return idx | IDX_W'(off);
    endfunction

    // Word `off` of a packed block; offset 0 is the most-significant word.
    function automatic logic [WORD_W-1:0] blockWord(input logic [BLK_W-1:0] blk, input int off);
        return blk[(WORDS_PER_BLOCK-1-off)*WORD_W +: WORD_W];
    endfunction

    // Power-on image: word[INIT_BASE+i] = i inside the pre-load window, 0 elsewhere.
    function automatic logic [WORD_W-1:0] initWord(input logic [IDX_W-1:0] idx);
        logic [63:0] i;
        i = 64'(idx);
        if (i >= 64'(INIT_BASE) && i < 64'(INIT_BASE) + 64'(INIT_COUNT))
            return WORD_W'(i - 64'(INIT_BASE));
        return '0;
    endfunction

    // The array holds each word XOR-ed with its power-on image, so an all-zero
    // array represents the pre-loaded contents without any load sequence.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    stateType          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              doneNext;
    logic [BLK_W-1:0]  outDataNext;
    logic [BLK_W-1:0]  readBlock;
    logic [ADDR_W-1:0] addrLat;
    logic [BLK_W-1:0]  dataLat;
    logic              accept;
    logic              commit;

    assign ready  = (state == IDLE);
    assign accept = ready && req;
    // Storage only changes on the final write edge, so an aborted write leaves it intact.
    assign commit = (state == WRITE) && (cnt == '0);

    // Transaction operands are plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addrLat <= address;
            dataLat <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                mem[wordIndex(addrLat, w)] <= blockWord(dataLat, w) ^ initWord(wordIndex(addrLat, w));
            end
        end
    end

    always_comb begin
        readBlock = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            readBlock[(WORDS_PER_BLOCK-1-w)*WORD_W +: WORD_W] =
                mem[wordIndex(addrLat, w)] ^ initWord(wordIndex(addrLat, w));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            outData <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            done    <= doneNext;
            outData <= outDataNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        doneNext    = 1'b0;
        outDataNext = outData;
        case (state)
            IDLE: begin
                if (req) begin
                    stateNext = we ? WRITE : READ;
                    cntNext   = we ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
                end
            end
            READ: begin
                if (cnt == '0) begin
                    stateNext   = IDLE;
                    doneNext    = 1'b1;
                    outDataNext = readBlock;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_timed_main_memory.sv
// -----------------------------------------------------------------------------
// tb_timed_main_memory
//
// Directed bench for timed_main_memory. dutA uses the default parameters,
// dutB uses READ_LATENCY=1, WRITE_LATENCY=7, WORDS_PER_BLOCK=8, WORD_W=16.
// Both block widths are 128 bits. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_timed_main_memory;

    localparam int AW = 13;
    localparam int BW = 128;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;

    logic          reqA  = 1'b0;
    logic          weA   = 1'b0;
    logic [AW-1:0] addrA = '0;
    logic [BW-1:0] inA   = '0;
    logic          readyA, doneA;
    logic [BW-1:0] outA;

    logic          reqB  = 1'b0;
    logic          weB   = 1'b0;
    logic [AW-1:0] addrB = '0;
    logic [BW-1:0] inB   = '0;
    logic          readyB, doneB;
    logic [BW-1:0] outB;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timed_main_memory dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (reqA),
        .we      (weA),
        .address (addrA),
        .inData  (inA),
        .ready   (readyA),
        .done    (doneA),
        .outData (outA)
    );

    timed_main_memory #(
        .READ_LATENCY    (1),
        .WRITE_LATENCY   (7),
        .WORDS_PER_BLOCK (8),
        .WORD_W          (16)
    ) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (reqB),
        .we      (weB),
        .address (addrB),
        .inData  (inB),
        .ready   (readyB),
        .done    (doneB),
        .outData (outB)
    );

    // Issues one transaction on dutA and returns once done is seen (or after a
    // 20-cycle bound). lat = edges from accept to done; lowCnt = cycles with
    // ready low before done. Returns 1 time unit into the done cycle.
    task automatic runTxnA(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                           output int lat, output int lowCnt);
        reqA = 1'b1; weA = wr; addrA = a; inA = d;
        @(posedge clk); #1;
        reqA = 1'b0;
        lat = 0;
        lowCnt = (readyA === 1'b0) ? 1 : 0;
        while (doneA !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (doneA !== 1'b1 && readyA === 1'b0) lowCnt++;
        end
    endtask

    task automatic runTxnB(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                           output int lat, output int lowCnt);
        reqB = 1'b1; weB = wr; addrB = a; inB = d;
        @(posedge clk); #1;
        reqB = 1'b0;
        lat = 0;
        lowCnt = (readyB === 1'b0) ? 1 : 0;
        while (doneB !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (doneB !== 1'b1 && readyB === 1'b0) lowCnt++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (readyA !== 1'b1) begin failures++; $display("FAIL reset_readyA got=%b want=1", readyA); end
        checks++; if (doneA !== 1'b0) begin failures++; $display("FAIL reset_doneA got=%b want=0", doneA); end
        checks++; if (outA !== '0) begin failures++; $display("FAIL reset_outA got=%h want=0", outA); end
        checks++; if (readyB !== 1'b1) begin failures++; $display("FAIL reset_readyB got=%b want=1", readyB); end
        checks++; if (doneB !== 1'b0) begin failures++; $display("FAIL reset_doneB got=%b want=0", doneB); end
        checks++; if (outB !== '0) begin failures++; $display("FAIL reset_outB got=%h want=0", outB); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_preload();
        int lat, low;
        @(negedge clk);
        runTxnA(1'b0, 13'd256, '0, lat, low);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rd256_latency got=%0d want=4", lat); end
        checks++; if (low !== 4) begin failures++; $display("FAIL rd256_ready_low got=%0d want=4", low); end
        checks++; if (outA !== 128'h00000000_00000001_00000002_00000003) begin
            failures++; $display("FAIL rd256_data got=%h want=%h", outA, 128'h00000000_00000001_00000002_00000003);
        end
        checks++; if (readyA !== 1'b1) begin failures++; $display("FAIL rd256_ready_at_done got=%b want=1", readyA); end
        @(posedge clk); #1;
        checks++; if (doneA !== 1'b0) begin failures++; $display("FAIL rd256_done_width got=%b want=0", doneA); end
        checks++; if (outA !== 128'h00000000_00000001_00000002_00000003) begin
            failures++; $display("FAIL rd256_data_hold got=%h", outA);
        end
    endtask

    task automatic test_read_edges();
        int lat, low;
        @(negedge clk);
        runTxnA(1'b0, 13'd0, '0, lat, low);
        checks++; if (outA !== '0) begin failures++; $display("FAIL rd0_data got=%h want=0", outA); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL rd0_latency got=%0d want=4", lat); end
        @(negedge clk);
        runTxnA(1'b0, 13'd2303, '0, lat, low);
        checks++; if (outA !== 128'h00001FFC_00001FFD_00001FFE_00001FFF) begin
            failures++; $display("FAIL rd2303_data got=%h want=%h", outA, 128'h00001FFC_00001FFD_00001FFE_00001FFF);
        end
        @(negedge clk);
        runTxnA(1'b0, 13'd2304, '0, lat, low);
        checks++; if (outA !== '0) begin failures++; $display("FAIL rd2304_data got=%h want=0", outA); end
    endtask

    task automatic test_back_to_back();
        int lat, low;
        logic [BW-1:0] d;
        d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        @(negedge clk);
        runTxnA(1'b1, 13'd8191, d, lat, low);
        checks++; if (lat !== 4) begin failures++; $display("FAIL wr8191_latency got=%0d want=4", lat); end
        checks++; if (low !== 4) begin failures++; $display("FAIL wr8191_ready_low got=%0d want=4", low); end
        checks++; if (readyA !== 1'b1) begin failures++; $display("FAIL wr8191_ready_at_done got=%b want=1", readyA); end
        checks++; if (outA !== '0) begin failures++; $display("FAIL wr8191_outdata_unchanged got=%h want=0", outA); end
        // request the read within the write's done cycle
        runTxnA(1'b0, 13'd8191, '0, lat, low);
        checks++; if (lat !== 4) begin failures++; $display("FAIL raw8191_latency got=%0d want=4", lat); end
        checks++; if (low !== 4) begin failures++; $display("FAIL raw8191_ready_low got=%0d want=4", low); end
        checks++; if (outA !== d) begin failures++; $display("FAIL raw8191_data got=%h want=%h", outA, d); end
    endtask

    task automatic test_busy_ignore();
        int dones, lat;
        @(negedge clk);
        reqA = 1'b1; weA = 1'b0; addrA = 13'd257;
        @(posedge clk); #1;
        dones = 0; lat = 0;
        for (int c = 1; c <= 12; c++) begin
            weA = ~weA;
            @(posedge clk); #1;
            if (doneA === 1'b1) begin
                dones++;
                if (dones == 1) lat = c;
                reqA = 1'b0;
            end
        end
        reqA = 1'b0; weA = 1'b0;
        checks++; if (dones !== 1) begin failures++; $display("FAIL busy_done_count got=%0d want=1", dones); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL busy_latency got=%0d want=4", lat); end
        checks++; if (outA !== 128'h00000004_00000005_00000006_00000007) begin
            failures++; $display("FAIL busy_rd257_data got=%h want=%h", outA, 128'h00000004_00000005_00000006_00000007);
        end
    endtask

    task automatic test_reset_abort();
        int dones, lat, low;
        @(negedge clk);
        reqA = 1'b1; weA = 1'b1; addrA = 13'd256; inA = '1;
        @(posedge clk); #1;
        reqA = 1'b0;
        dones = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (doneA === 1'b1) dones++;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (readyA !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", readyA); end
        checks++; if (outA !== '0) begin failures++; $display("FAIL abort_outdata got=%h want=0", outA); end
        repeat (2) begin
            @(posedge clk); #1;
            if (doneA === 1'b1) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (doneA === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_done_count got=%0d want=0", dones); end
        @(negedge clk);
        runTxnA(1'b0, 13'd256, '0, lat, low);
        checks++; if (outA !== 128'h00000000_00000001_00000002_00000003) begin
            failures++; $display("FAIL abort_rd256_data got=%h want=%h", outA, 128'h00000000_00000001_00000002_00000003);
        end
    endtask

    task automatic test_alt_params();
        int lat, low;
        logic [BW-1:0] d;
        d = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        @(negedge clk);
        runTxnB(1'b0, 13'd128, '0, lat, low);
        checks++; if (lat !== 1) begin failures++; $display("FAIL b_rd128_latency got=%0d want=1", lat); end
        checks++; if (low !== 1) begin failures++; $display("FAIL b_rd128_ready_low got=%0d want=1", low); end
        checks++; if (outB !== 128'h0000_0001_0002_0003_0004_0005_0006_0007) begin
            failures++; $display("FAIL b_rd128_data got=%h want=%h", outB, 128'h0000_0001_0002_0003_0004_0005_0006_0007);
        end
        @(negedge clk);
        runTxnB(1'b0, 13'd1151, '0, lat, low);
        checks++; if (outB !== 128'h1FF8_1FF9_1FFA_1FFB_1FFC_1FFD_1FFE_1FFF) begin
            failures++; $display("FAIL b_rd1151_data got=%h want=%h", outB, 128'h1FF8_1FF9_1FFA_1FFB_1FFC_1FFD_1FFE_1FFF);
        end
        @(negedge clk);
        runTxnB(1'b1, 13'd8191, d, lat, low);
        checks++; if (lat !== 7) begin failures++; $display("FAIL b_wr8191_latency got=%0d want=7", lat); end
        checks++; if (low !== 7) begin failures++; $display("FAIL b_wr8191_ready_low got=%0d want=7", low); end
        runTxnB(1'b0, 13'd8191, '0, lat, low);
        checks++; if (lat !== 1) begin failures++; $display("FAIL b_raw8191_latency got=%0d want=1", lat); end
        checks++; if (outB !== d) begin failures++; $display("FAIL b_raw8191_data got=%h want=%h", outB, d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_preload();
        test_read_edges();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_alt_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
